// File: rtl/shot_sequencer.sv
// Shot sequencer for the basketball game: debounced shoot button, physics tick
// divider, AIM/FLIGHT/RESULT flow and shot/make scoring.
module shot_sequencer #(
  parameter int TICK_DIV   = 1000000,
  parameter int DEBOUNCE   = 65536,
  parameter int MAX_FLIGHT = 1000,
  parameter int SETTLE     = 200,
  parameter int HOOP_XL    = 610,
  parameter int HOOP_XR    = 630,
  parameter int HOOP_Y     = 157,
  parameter int FLOOR_Y    = 475
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  output logic       phys_tick,
  output logic       sample_en,
  output logic       launch,
  output logic       hold_init,
  output logic [1:0] state,
  output logic       result_valid,
  output logic       result_made,
  output logic [7:0] shots,
  output logic [7:0] makes
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int FL_W  = (MAX_FLIGHT > 1) ? $clog2(MAX_FLIGHT) : 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(MAX_FLIGHT - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

  localparam logic [9:0] HOOP_XL_PX = 10'(HOOP_XL);
  localparam logic [9:0] HOOP_XR_PX = 10'(HOOP_XR);
  localparam logic [9:0] HOOP_Y_PX  = 10'(HOOP_Y);
  localparam logic [9:0] FLOOR_Y_PX = 10'(FLOOR_Y);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AIM    = 2'd1,
    FLIGHT = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t             state_r, state_nx_s;
  logic               sync1_r, sync2_r, btn_stable_r, btn_prev_r;
  logic [DB_W-1:0]    db_cnt_r;
  logic [DIV_W-1:0]   div_r;
  logic [FL_W-1:0]    flight_cnt_r;
  logic [SET_W-1:0]   settle_cnt_r;
  logic [9:0]         prev_y_r;
  logic               tick_s, rise_s, fall_s;
  logic               score_s, floor_s, timeout_s, settle_last_s;
  logic               launch_nx_s, resolve_s;

  assign tick_s        = (div_r == DIV_LAST);
  assign rise_s        = btn_stable_r & ~btn_prev_r;
  assign fall_s        = ~btn_stable_r & btn_prev_r;
  assign score_s       = (prev_y_r < HOOP_Y_PX) && (ball_y >= HOOP_Y_PX) &&
                         (ball_x > HOOP_XL_PX) && (ball_x < HOOP_XR_PX);
  assign floor_s       = (ball_y >= FLOOR_Y_PX);
  assign timeout_s     = (flight_cnt_r == FL_LAST);
  assign settle_last_s = (settle_cnt_r == SET_LAST);
  assign launch_nx_s   = (state_r == AIM) && (state_nx_s == FLIGHT);
  assign resolve_s     = (state_r == FLIGHT) && (state_nx_s == RESULT);

  assign state     = state_r;
  assign phys_tick = tick_s && (state_r == FLIGHT);
  assign sample_en = tick_s && (state_r == AIM);

  // Button synchroniser and debouncer; a single agreeing cycle restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r      <= 1'b0;
      sync2_r      <= 1'b0;
      btn_stable_r <= 1'b0;
      btn_prev_r   <= 1'b0;
      db_cnt_r     <= '0;
    end else begin
      sync1_r    <= btn;
      sync2_r    <= sync1_r;
      btn_prev_r <= btn_stable_r;
      if (sync2_r != btn_stable_r) begin
        if (db_cnt_r == DB_LAST) begin
          btn_stable_r <= sync2_r;
          db_cnt_r     <= '0;
        end else begin
          db_cnt_r <= db_cnt_r + DB_W'(1);
        end
      end else begin
        db_cnt_r <= '0;
      end
    end
  end

  // Free-running physics tick divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r <= '0;
    end else if (tick_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state; button edges only matter in IDLE and AIM.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (rise_s) state_nx_s = AIM;
        else        state_nx_s = IDLE;
      end
      AIM: begin
        if (fall_s) state_nx_s = FLIGHT;
        else        state_nx_s = AIM;
      end
      FLIGHT: begin
        if (tick_s && (score_s || floor_s || timeout_s)) state_nx_s = RESULT;
        else                                               state_nx_s = FLIGHT;
      end
      RESULT: begin
        if (tick_s && settle_last_s) state_nx_s = IDLE;
        else                         state_nx_s = RESULT;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Flight tracking, scoring counters and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      launch       <= 1'b0;
      result_valid <= 1'b0;
      result_made  <= 1'b0;
      hold_init    <= 1'b1;
      shots        <= 8'd0;
      makes        <= 8'd0;
      prev_y_r     <= 10'd0;
      flight_cnt_r <= '0;
      settle_cnt_r <= '0;
    end else begin
      launch       <= launch_nx_s;
      result_valid <= resolve_s;
      hold_init    <= (state_nx_s != FLIGHT);
      if (launch_nx_s) begin
        if (shots != 8'd255) shots <= shots + 8'd1;
        else                 shots <= shots;
        prev_y_r     <= ball_y;
        flight_cnt_r <= '0;
      end else if ((state_r == FLIGHT) && tick_s) begin
        if (resolve_s) begin
          result_made <= score_s;
          if (score_s && (makes != 8'd255)) makes <= makes + 8'd1;
          else                              makes <= makes;
        end else begin
          prev_y_r     <= ball_y;
          flight_cnt_r <= flight_cnt_r + FL_W'(1);
        end
      end else begin
        prev_y_r <= prev_y_r;
      end
      // Settle count restarts whenever we are outside RESULT.
      if (state_r != RESULT) settle_cnt_r <= '0;
      else if (tick_s)       settle_cnt_r <= settle_cnt_r + SET_W'(1);
      else                   settle_cnt_r <= settle_cnt_r;
    end
  end

endmodule
